// File: rtl/proc_trace_buffer.sv
// Trace capture unit: arm, wait for a PC trigger, record retired instructions into a FWFT FIFO.
// Optional PROC_TRACE_TIMESTAMP_EN prefixes each record with a 16-bit free-running cycle stamp.
module proc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
`ifdef PROC_TRACE_TIMESTAMP_EN
  parameter int TS_W   = 16,
`else
  parameter int TS_W   = 0,
`endif
  parameter int REC_W  = TS_W + PC_W + 2*DATA_W + 1 + REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              clear,
  input  logic              trig_any,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic              stop_on_full,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              in_reg_write,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic [DATA_W-1:0] in_write_data,
  output logic [REC_W-1:0]  rec_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ADDR_W:0]   count,
  output logic [15:0]       overflow_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, CAPTURE = 2'b10, DONE = 2'b11} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  state_t            st;
  logic              arm_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [REC_W-1:0]  rec_in;
  logic              full, pop, want, push, drop, stop_hit;

`ifdef PROC_TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  always_ff @(posedge clk or posedge reset)
    if (reset) ts <= '0;
    else       ts <= ts + 16'd1;
  assign rec_in = {ts, in_pc, in_instr, in_reg_write, in_write_reg, in_write_data};
`else
  assign rec_in = {in_pc, in_instr, in_reg_write, in_write_reg, in_write_data};
`endif

  // Output is gated by occupancy so an async reset presents zero data at once
  assign rec_valid = (count != '0);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;
  assign state     = st;

  assign full  = (count == FULL_CNT);
  assign pop   = rec_valid && rec_ready && !clear;
  assign want  = in_valid && arm && !clear &&
                 ((st == ARMED && (trig_any || in_pc == trig_pc)) || st == CAPTURE);
  assign push  = want && (!full || pop);
  assign drop  = want && full && !pop && !stop_on_full;
  // Stop when this write fills the FIFO, or a record arrives that cannot fit
  assign stop_hit = stop_on_full && (push ? (!pop && count == LAST_CNT) : want);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rec_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      arm_q        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      arm_q <= arm;
      if (clear) begin
        st           <= IDLE;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        overflow_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
        if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        case (st)
          IDLE:           if (arm && !arm_q) st <= ARMED;
          ARMED, CAPTURE: if (!arm) st <= IDLE;
                          else if (want) st <= stop_hit ? DONE : CAPTURE;
          DONE:           if (!arm) st <= IDLE;
          default:        st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Hardware trace capture unit for the 16-bit processor; the on-chip consumer of the per-instruction state the simulation bench prints (PC, instruction, register write-back).
- Arms, waits for a PC trigger, records retired-instruction records into a FIFO, and hands them to a downstream reader (UART transmitter or debug port) over a valid/ready interface.

Parameters:
- DEPTH, 16, FIFO entries; power of two.
- ADDR_W, 4, log2(DEPTH).
- PC_W, 16, program counter width.
- DATA_W, 16, instruction and write-data width.
- REG_W, 3, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- arm  in  1  level; 0->1 edge moves IDLE->ARMED.
- clear  in  1  pulse; flushes FIFO and overflow count, returns to IDLE.
- trig_any  in  1  1 = trigger on first valid record regardless of PC.
- trig_pc  in  PC_W  trigger PC value.
- stop_on_full  in  1  1 = stop at full (DONE); 0 = keep running and count drops.
- in_valid  in  1  one retired instruction this cycle.
- in_pc  in  PC_W  PC of the retired instruction.
- in_instr  in  DATA_W  instruction word.
- in_reg_write  in  1  write-back enable.
- in_write_reg  in  REG_W  destination register.
- in_write_data  in  DATA_W  write-back value.
- rec_data  out  REC_W  head record {pc, instr, reg_write, write_reg, write_data}; REC_W = PC_W+2*DATA_W+1+REG_W (52 by default).
- rec_valid  out  1  head record available.
- rec_ready  in  1  reader accepts the head record.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_cnt  out  16  dropped records; saturates at 0xFFFF.
- state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.

Behaviour:
- Reset values: state=IDLE, count=0, rec_valid=0, rec_data=0, overflow_cnt=0; FIFO pointers=0.
- IDLE: no capture. Rising edge of arm (registered) -> ARMED.
- ARMED: on in_valid && (trig_any || in_pc==trig_pc) -> CAPTURE. The triggering record is written that same cycle.
- CAPTURE: every in_valid cycle writes one record. Write latency: a record written at edge N is visible on rec_data/rec_valid after edge N (first-word fall-through from registered memory).
- Full, stop_on_full=1: the write that fills the FIFO moves state to DONE. Subsequent records are ignored and not counted.
- Full, stop_on_full=0: stay in CAPTURE. Each in_valid with the FIFO full and no simultaneous pop increments overflow_cnt.
- arm falling to 0 in ARMED or CAPTURE -> IDLE. FIFO contents are kept.
- DONE -> IDLE when arm=0.
- Read side: a pop occurs when rec_valid && rec_ready. Popping is allowed in every state. rec_valid = (count != 0).
- Simultaneous push and pop: count unchanged, both pointers advance. A push when full succeeds only if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH. count uses ADDR_W+1 bits to distinguish full from empty.
- clear has priority over push and pop: pointers=0, count=0, overflow_cnt=0, state=IDLE on the next edge.
- reset mid-capture: asynchronously empties the FIFO and drops any in-flight record. The reader sees rec_valid fall immediately.

Optional Feature:
- Macro: PROC_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0 and wrapping at 0xFFFF.
  - Each record is prefixed with the counter value at capture time.
  - REC_W grows by 16; rec_data = {timestamp, pc, instr, reg_write, write_reg, write_data}.
- Not defined: no counter logic; REC_W as listed under Ports.

Test Plan:
- Reset with DEPTH=16, then arm=1, trig_any=0, trig_pc=0x0004, in_valid every cycle with pc=0..9 -> state goes ARMED then CAPTURE at pc=4; count=6; first popped record has pc=0x0004.
- trig_any=1, stop_on_full=1, 20 valid records, rec_ready=0 -> count=16, state=DONE, overflow_cnt=0; popping all 16 returns pc 0..15 in order, then rec_valid=0.
- stop_on_full=0, 20 records, rec_ready=0 -> count=16, overflow_cnt=4, state=CAPTURE.
- FIFO full, in_valid and rec_ready both high for 5 cycles -> count stays 16, overflow_cnt unchanged, popped pc values strictly increasing.
- clear pulse with count=7 and overflow_cnt=3 -> next cycle count=0, overflow_cnt=0, state=IDLE, rec_valid=0.
- reset asserted mid-CAPTURE between clock edges -> outputs reach reset values before the next edge; with PROC_TRACE_TIMESTAMP_EN, the first record after re-arm carries a timestamp equal to cycles elapsed since reset release.
